// File: rtl/verdict_pkg.sv
// verdict_pkg: shared widths, header field offsets, FSM state encoding and
// the set-bit search helpers used by verdict_serializer.
//   DATA_W     width of one monitor output value and of one stream beat
//   TS_W       cycle timestamp width
//   MASK_W     width of the mask field in the header beat
//   HDR_*_LSB  header field offsets
//   state_e    IDLE / HDR / DATA packet FSM states
package verdict_pkg;

  localparam int DATA_W       = 64;
  localparam int TS_W         = 48;
  localparam int MASK_W       = 16;
  localparam int IDX_W        = $clog2(MASK_W);
  localparam int HDR_MASK_LSB = 0;
  localparam int HDR_TS_LSB   = MASK_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Lowest set bit of mask at or above position 'from'. Scanning downward
  // lets the lowest qualifying bit win without a priority chain in the source.
  function automatic logic [IDX_W-1:0] next_set(input logic [MASK_W-1:0] mask,
                                                input logic [IDX_W:0]    from);
    logic [IDX_W-1:0] res;
    res = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) res = IDX_W'(i);
    end
    return res;
  endfunction

  // True when no mask bit above idx is set, i.e. idx is the final data beat.
  function automatic logic is_last(input logic [MASK_W-1:0] mask,
                                   input logic [IDX_W-1:0]  idx);
    logic [MASK_W-1:0] above;
    above = mask >> ({1'b0, idx} + (IDX_W + 1)'(1));
    return (above == '0);
  endfunction

endpackage

// File: rtl/verdict_serializer_if.sv
// verdict_serializer_if: 64-bit valid/ready beat stream.
//   m_data   beat payload
//   m_valid  beat valid (source)
//   m_last   final beat of packet (source)
//   m_ready  sink accepts beat (sink)
// master = stream source, slave = stream sink.
interface verdict_serializer_if;
  import verdict_pkg::*;

  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/verdict_serializer_fifo.sv
// snapshot_fifo: single-clock FIFO holding captured monitor snapshots.
//   clk, rst        clock, asynchronous active-low reset
//   push/push_data  write request; accepted when not full, or when full and
//                   a pop happens on the same edge (pop frees the slot first)
//   pop             remove the head entry
//   head            current head entry, read combinationally
//   full/empty      occupancy flags
//   more_than_one   at least two entries stored
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module snapshot_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             more_than_one
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: storage has no reset; only pointers and count define validity, so
  // the array stays a plain RAM without a reset network.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head          = mem[rd_ptr];
  assign full          = (count == (AW + 1)'(DEPTH));
  assign empty         = (count == '0);
  assign more_than_one = (count > (AW + 1)'(1));

endmodule

// File: rtl/verdict_serializer.sv
// verdict_serializer: captures every enabled cycle with any monitor aktv flag
// set, buffers the snapshots and emits them as packets of 64-bit beats
// (one header beat, then one beat per active output, ascending index).
//   clk, rst   clock, asynchronous active-low reset
//   en         monitor enable; gates capture and timestamp advance only
//   out_data   NUM_OUT signed 64-bit monitor values, output k at [64k+63:64k]
//   out_aktv   per-output aktv flags
//   m          beat stream (master side)
//   drop_cnt   snapshots lost to a full FIFO, saturating
//   busy       FIFO non-empty or packet in flight
// Build option: VERDICT_TIMESTAMP_EN adds the 48-bit cycle timestamp to the
// header; without it the counter is not built and header[63:16] is zero.
// A snapshot occupies its FIFO slot until its last beat is accepted; the
// header/data beats are read straight from the FIFO head.
module verdict_serializer
  import verdict_pkg::*;
#(
  parameter int NUM_OUT = 10,
  parameter int DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_OUT*DATA_W-1:0] out_data,
  input  logic [NUM_OUT-1:0]        out_aktv,
  verdict_serializer_if.master      m,
  output logic [15:0]               drop_cnt,
  output logic                      busy
);

`ifdef VERDICT_TIMESTAMP_EN
  localparam int SNAP_W = TS_W + NUM_OUT + NUM_OUT * DATA_W;
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    ts <= '0;
    else if (en) ts <= ts + TS_W'(1);
  end
`else
  localparam int SNAP_W = NUM_OUT + NUM_OUT * DATA_W;
`endif

  // One register stage between the monitor and the FIFO keeps the monitor
  // outputs off the FIFO write path.
  logic              cap_vld;
  logic [SNAP_W-1:0] cap_snap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cap_vld <= 1'b0;
    else      cap_vld <= en && (|out_aktv);
  end

  always_ff @(posedge clk) begin
    if (en && (|out_aktv)) begin
`ifdef VERDICT_TIMESTAMP_EN
      cap_snap <= {ts, out_aktv, out_data};
`else
      cap_snap <= {out_aktv, out_data};
`endif
    end
  end

  logic [SNAP_W-1:0] head;
  logic              full;
  logic              empty;
  logic              more_than_one;
  logic              pop;

  snapshot_fifo #(.WIDTH(SNAP_W), .DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push          (cap_vld),
    .push_data     (cap_snap),
    .pop           (pop),
    .head          (head),
    .full          (full),
    .empty         (empty),
    .more_than_one (more_than_one)
  );

  logic [NUM_OUT-1:0]             head_mask;
  logic [NUM_OUT-1:0][DATA_W-1:0] head_words;
  logic [TS_W-1:0]                head_ts;
  logic [MASK_W-1:0]              mask16;

`ifdef VERDICT_TIMESTAMP_EN
  assign {head_ts, head_mask, head_words} = head;
`else
  assign {head_mask, head_words} = head;
  assign head_ts = '0;
`endif
  assign mask16 = MASK_W'(head_mask);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt <= '0;
    else if (cap_vld && full && !pop && (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'd1;
  end

  state_e           state_q;
  state_e           state_d;
  logic [IDX_W-1:0] idx_q;
  logic             last_beat;

  assign last_beat = is_last(mask16, idx_q);
  assign pop       = (state_q == ST_DATA) && m.m_ready && last_beat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // idx walks the set mask bits; it is loaded as the header is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
    end else if ((state_q == ST_HDR) && m.m_ready) begin
      idx_q <= next_set(mask16, '0);
    end else if ((state_q == ST_DATA) && m.m_ready && !last_beat) begin
      idx_q <= next_set(mask16, {1'b0, idx_q} + (IDX_W + 1)'(1));
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!empty) state_d = ST_HDR;
      ST_HDR:  if (m.m_ready) state_d = ST_DATA;
      ST_DATA: begin
        // After the pop the FIFO still holds a snapshot if two were stored
        // or one is being pushed on this edge: go straight to its header.
        if (m.m_ready && last_beat)
          state_d = (more_than_one || cap_vld) ? ST_HDR : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m.m_valid = 1'b0;
    m.m_last  = 1'b0;
    m.m_data  = '0;
    case (state_q)
      ST_HDR: begin
        m.m_valid = 1'b1;
        m.m_data  = {head_ts, mask16};
      end
      ST_DATA: begin
        m.m_valid = 1'b1;
        m.m_last  = last_beat;
        m.m_data  = head_words[idx_q];
      end
      default: ;
    endcase
  end

  assign busy = !empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_verdict_serializer.sv
// tb_verdict_serializer: self-checking bench for verdict_serializer
// (NUM_OUT=10, DEPTH=4). A negedge monitor keeps a queue of captured
// snapshots and matches each received packet against it in order; snapshots
// skipped over must equal drop_cnt. Works with or without VERDICT_TIMESTAMP_EN.
module tb_verdict_serializer;
  import verdict_pkg::*;

  localparam int N = 10;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en  = 1'b0;
  logic [N*64-1:0] out_data = '0;
  logic [N-1:0]   out_aktv = '0;
  logic [15:0]    drop_cnt;
  logic           busy;

  verdict_serializer_if bus ();

  verdict_serializer #(.NUM_OUT(N), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .out_data (out_data),
    .out_aktv (out_aktv),
    .m        (bus),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [47:0]        ts;
    logic [N-1:0]       mask;
    logic [N-1:0][63:0] d;
  } snap_t;

  snap_t       exp_q[$];
  logic [64:0] rx_pkt[$];
  logic [47:0] model_ts = '0;
  int          n_pkts = 0;
  int          n_skipped = 0;
  logic        prev_stall = 1'b0;
  logic [64:0] prev_beat = '0;

  function automatic logic [63:0] exp_header(input snap_t s);
`ifdef VERDICT_TIMESTAMP_EN
    return {s.ts, 16'(s.mask)};
`else
    return {48'd0, 16'(s.mask)};
`endif
  endfunction

  function automatic bit pkt_matches(input snap_t s);
    logic [64:0] e[$];
    e.push_back({1'b0, exp_header(s)});
    for (int k = 0; k < N; k++) if (s.mask[k]) e.push_back({1'b0, s.d[k]});
    e[e.size() - 1][64] = 1'b1;
    if (e.size() != rx_pkt.size()) return 1'b0;
    for (int i = 0; i < e.size(); i++) if (e[i] !== rx_pkt[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic score_packet();
    bit matched = 1'b0;
    while (!matched && exp_q.size() > 0) begin
      if (pkt_matches(exp_q[0])) matched = 1'b1;
      else n_skipped++;
      void'(exp_q.pop_front());
    end
    n_pkts++;
    check($sformatf("packet hdr=%h beats=%0d", rx_pkt[0][63:0], rx_pkt.size()),
          {63'd0, matched}, 64'd1);
    rx_pkt.delete();
  endtask

  // Negedge: values seen here are what the DUT samples on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      rx_pkt.delete();
      model_ts   = '0;
      n_skipped  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {63'd0, bus.m_valid}, 64'd1);
        check("hold_data", bus.m_data, prev_beat[63:0]);
        check("hold_last", {63'd0, bus.m_last}, {63'd0, prev_beat[64]});
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_beat  = {bus.m_last, bus.m_data};
      if (bus.m_valid && bus.m_ready) begin
        rx_pkt.push_back({bus.m_last, bus.m_data});
        if (bus.m_last) score_packet();
      end
      if (en && (|out_aktv)) begin
        snap_t s;
        s.ts   = model_ts;
        s.mask = out_aktv;
        s.d    = out_data;
        exp_q.push_back(s);
      end
      if (en) model_ts = model_ts + 48'd1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en = 1'b0;
    out_aktv = '0;
    bus.m_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic set_data(input logic [63:0] base);
    for (int k = 0; k < N; k++) out_data[k*64 +: 64] = base + 64'(k);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    repeat (2) tick();
    while ((busy || bus.m_valid) && c < budget) begin
      tick();
      c++;
    end
    if (busy || bus.m_valid) check("drain_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic run_to_ts(input logic [47:0] target);
    int c = 0;
    while (model_ts != target && c < 5000) begin
      tick();
      c++;
    end
    check("reach_ts", 64'(model_ts), 64'(target));
  endtask

  task automatic check_drops(input string name);
    check(name, 64'(n_skipped + exp_q.size()), 64'(drop_cnt));
  endtask

  typedef struct {
    logic [N-1:0] mask;
    logic [63:0]  base;
    logic [15:0]  exp_hdr_mask;
    int           exp_beats;
    logic [63:0]  exp_last;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] hdr_exp;
    int          pk0;
    int          bubbles;
    int          c;
    int          vcount;

    tbl[0] = '{10'h3FF, 64'd1,     16'h03FF, 11, 64'd10};
    tbl[1] = '{10'h001, 64'd1,     16'h0001, 2,  64'd1};
    tbl[2] = '{10'h200, 64'h100,   16'h0200, 2,  64'h109};
    tbl[3] = '{10'h205, 64'h50,    16'h0205, 4,  64'h59};
    tbl[4] = '{10'h155, 64'd7,     16'h0155, 6,  64'd15};
    tbl[5] = '{10'h2AA, 64'h20,    16'h02AA, 6,  64'h29};

    bus.m_ready = 1'b0;
    #1;
    // Reset state
    check("rst_valid", {63'd0, bus.m_valid}, 64'd0);
    check("rst_last", {63'd0, bus.m_last}, 64'd0);
    check("rst_data", bus.m_data, 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    do_reset();

    // Single output at ts=500, with header latency
    en = 1'b1;
    bus.m_ready = 1'b1;
    run_to_ts(48'd500);
    out_data = '0;
    out_data[63:0] = 64'd1;
    out_aktv = 10'h001;
    tick();
    out_aktv = '0;
    tick();
    check("lat_n1_valid", {63'd0, bus.m_valid}, 64'd0);
    tick();
`ifdef VERDICT_TIMESTAMP_EN
    hdr_exp = {48'd500, 16'h0001};
`else
    hdr_exp = {48'd0, 16'h0001};
`endif
    check("lat_n2_valid", {63'd0, bus.m_valid}, 64'd1);
    check("t1_header", bus.m_data, hdr_exp);
    check("t1_hdr_last", {63'd0, bus.m_last}, 64'd0);
    tick();
    check("t1_beat", bus.m_data, 64'd1);
    check("t1_beat_last", {63'd0, bus.m_last}, 64'd1);
    tick();
    check("t1_idle", {63'd0, bus.m_valid}, 64'd0);
    wait_idle(50);

    // Table-driven single packets
    for (int i = 0; i < 6; i++) begin
      int beats;
      logic [63:0] hdr;
      logic [63:0] lastv;
      set_data(tbl[i].base);
      out_aktv = tbl[i].mask;
      tick();
      out_aktv = '0;
      beats = 0;
      c = 0;
      hdr = '0;
      lastv = '0;
      while (c < 40) begin
        if (bus.m_valid) begin
          if (beats == 0) hdr = bus.m_data;
          beats++;
          if (bus.m_last) begin
            lastv = bus.m_data;
            break;
          end
        end
        tick();
        c++;
      end
      check($sformatf("tbl%0d_mask", i), {48'd0, hdr[15:0]}, {48'd0, tbl[i].exp_hdr_mask});
      check($sformatf("tbl%0d_beats", i), 64'(beats), 64'(tbl[i].exp_beats));
      check($sformatf("tbl%0d_last", i), lastv, tbl[i].exp_last);
      wait_idle(50);
    end

    // Back-pressure on the beat for output 2
    set_data(64'hA00);
    out_aktv = 10'h205;
    tick();
    out_aktv = '0;
    c = 0;
    while (!(bus.m_valid && bus.m_data == 64'hA02) && c < 20) begin
      tick();
      c++;
    end
    bus.m_ready = 1'b0;
    repeat (5) begin
      tick();
      check("stall_data", bus.m_data, 64'hA02);
      check("stall_last", {63'd0, bus.m_last}, 64'd0);
    end
    bus.m_ready = 1'b1;
    tick();
    check("after_stall_data", bus.m_data, 64'hA09);
    check("after_stall_last", {63'd0, bus.m_last}, 64'd1);
    tick();
    check("after_stall_idle", {63'd0, bus.m_valid}, 64'd0);
    wait_idle(50);

    // Overflow: 6 captures into a 4-deep FIFO with the sink stalled
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_data(64'(i) << 8);
      out_aktv = 10'h200 | 10'(1 << i);
      tick();
    end
    out_aktv = '0;
    repeat (3) tick();
    check("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
    check("ovf_busy", {63'd0, busy}, 64'd1);
    pk0 = n_pkts;
    bubbles = 0;
    c = 0;
    bus.m_ready = 1'b1;
    while (busy && c < 200) begin
      tick();
      c++;
      if (busy && !bus.m_valid) bubbles++;
    end
    check("ovf_packets", 64'(n_pkts - pk0), 64'd4);
    check("ovf_bubbles", 64'(bubbles), 64'd0);
    check_drops("ovf_drop_account");

    // Asynchronous reset in the middle of a data beat
    set_data(64'hC00);
    out_aktv = 10'h3FF;
    tick();
    out_aktv = '0;
    c = 0;
    while (!(bus.m_valid && bus.m_data == 64'hC03) && c < 20) begin
      tick();
      c++;
    end
    rst = 1'b0;
    #1;
    check("arst_valid", {63'd0, bus.m_valid}, 64'd0);
    check("arst_drop", 64'(drop_cnt), 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    pk0 = n_pkts;
    set_data(64'hD00);
    out_aktv = 10'h081;
    tick();
    out_aktv = '0;
    wait_idle(50);
    check("arst_clean_packet", 64'(n_pkts - pk0), 64'd1);

    // Capture at ts=1000, then en low with aktv high
    do_reset();
    en = 1'b1;
    bus.m_ready = 1'b1;
    run_to_ts(48'd1000);
    set_data(64'h40);
    out_aktv = 10'h010;
    tick();
    out_aktv = '0;
    repeat (2) tick();
`ifdef VERDICT_TIMESTAMP_EN
    hdr_exp = {48'd1000, 16'h0010};
`else
    hdr_exp = {48'd0, 16'h0010};
`endif
    check("ts1000_header", bus.m_data, hdr_exp);
    wait_idle(50);
    en = 1'b0;
    out_aktv = 10'h3FF;
    vcount = 0;
    repeat (20) begin
      tick();
      if (bus.m_valid) vcount++;
    end
    out_aktv = '0;
    check("en_low_no_valid", 64'(vcount), 64'd0);
    check("en_low_busy", {63'd0, busy}, 64'd0);
    check("en_low_queue", 64'(exp_q.size()), 64'd0);

    // Randomized traffic against the scoreboard
    do_reset();
    pk0 = n_pkts;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      en = ($urandom_range(0, 7) != 0);
      bus.m_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) out_data[k*64 +: 64] = {$urandom, $urandom};
      out_aktv = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      tick();
    end
    out_aktv = '0;
    bus.m_ready = 1'b1;
    wait_idle(500);
    check("rand_some_packets", 64'(n_pkts > pk0), 64'd1);
    check("rand_queue_left", 64'(exp_q.size()), 64'd0);
    check_drops("rand_drop_account");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
